tdc_multi_channel: RTL and testbench

- Parametrised successor to the single-channel TDC: N_CH hit channels share one coarse counter.
- Each channel's rising hit edge is stamped with {coarse count, fine code}. The fine code comes from the channel's sampled delay-line thermometer word.
- Stamps are arbitrated round-robin into one FIFO and read out over a valid/ready interface.
- Sits between the per-channel delay-line samplers and the readout/packetiser.

---
 rtl/tdc_pkg.sv | 35 +++
 rtl/tdc_ts_fifo.sv | 43 ++++
 rtl/tdc_multi_channel.sv | 146 ++++++++++++++
 tb/tb_tdc_multi_channel.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared width helpers and fine-code functions for the multi-channel TDC
package tdc_pkg;

    localparam int MAX_THERMO_W = 64;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int fine_width(input int thermo_w);
        return $clog2(thermo_w + 1);
    endfunction

    function automatic int unsigned popcount(input logic [MAX_THERMO_W-1:0] w);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_THERMO_W; i++) begin
            n = n + 32'(w[i]);
        end
        return n;
    endfunction

    // Three-tap majority; the word must be zero-extended so bit THERMO_W reads as 0.
    function automatic logic [MAX_THERMO_W-1:0] bubble_fix(input logic [MAX_THERMO_W-1:0] w);
        logic [MAX_THERMO_W+1:0] ext;
        logic [MAX_THERMO_W-1:0] r;
        ext = {1'b0, w, 1'b1};
        r   = '0;
        for (int i = 0; i < MAX_THERMO_W; i++) begin
            r[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
        return r;
    endfunction

endpackage

// File: rtl/tdc_ts_fifo.sv
// rtl/tdc_ts_fifo.sv - synchronous show-ahead timestamp FIFO, generic entry type
module tdc_ts_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  T     push_data_i,
    input  logic pop_i,
    output T     head_o,
    output logic valid_o,
    output logic full_o
);

    localparam int AW = $clog2(DEPTH);

    T           mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic        do_push, do_pop;

    // Full is derived from registered pointers only, so a same-cycle pop never frees a slot early.
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign valid_o = (wr_q != rd_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && valid_o;
    assign head_o  = valid_o ? mem_q[rd_q[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/tdc_multi_channel.sv
// rtl/tdc_multi_channel.sv - N-channel TDC with shared coarse counter, round-robin FIFO readout (TDC_BUBBLE_FIX_EN)
module tdc_multi_channel
    import tdc_pkg::*;
#(
    parameter  int N_CH       = 4,
    parameter  int THERMO_W   = 8,
    parameter  int COARSE_W   = 12,
    parameter  int FIFO_DEPTH = 8,
    localparam int CH_W       = ch_width(N_CH),
    localparam int FINE_W     = fine_width(THERMO_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [N_CH-1:0]            hit_in,
    input  logic [N_CH*THERMO_W-1:0]   thermo_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CH_W-1:0]            out_channel,
    output logic [COARSE_W-1:0]        out_coarse,
    output logic [FINE_W-1:0]          out_fine,
    output logic [N_CH-1:0]            drop_flags,
    output logic                       coarse_wrap
);

    typedef struct packed {
        logic [CH_W-1:0]     channel;
        logic [COARSE_W-1:0] coarse;
        logic [FINE_W-1:0]   fine;
    } ts_t;

    logic [COARSE_W-1:0] coarse_q, coarse_d;
    logic                wrap_q, wrap_d;
    logic [N_CH-1:0]     hit_q;
    logic [N_CH-1:0]     pending_q, pending_d;
    logic [N_CH-1:0]     drop_q, drop_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [COARSE_W-1:0] st_coarse_q [N_CH];
    logic [FINE_W-1:0]   st_fine_q   [N_CH];

    logic [N_CH-1:0]     hit_edge, capture_c, grant;
    logic [CH_W-1:0]     gnt_idx;
    logic                found;
    logic [FINE_W-1:0]   fine_c [N_CH];
    logic [MAX_THERMO_W-1:0] word;
    logic                fifo_full, fifo_valid;
    ts_t                 push_ts, head_ts;

    always_comb begin
        word   = '0;
        fine_c = '{default: '0};
        for (int c = 0; c < N_CH; c++) begin
            word = MAX_THERMO_W'(thermo_in[c*THERMO_W +: THERMO_W]);
`ifdef TDC_BUBBLE_FIX_EN
            word = bubble_fix(word);
`endif
            fine_c[c] = FINE_W'(popcount(word));
        end
    end

    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        ptr_d   = ptr_q;
        if (!fifo_full) begin
            for (int i = 0; i < N_CH; i++) begin
                idx = (int'(ptr_q) + i) % N_CH;
                if (!found && pending_q[idx]) begin
                    found        = 1'b1;
                    grant[idx]   = 1'b1;
                    gnt_idx      = CH_W'(idx);
                end
            end
        end
        if (found) ptr_d = CH_W'((int'(gnt_idx) + 1) % N_CH);
    end

    // A grant frees the slot this cycle, so a same-cycle edge on that channel is a capture, not a loss.
    always_comb begin
        hit_edge  = hit_in & ~hit_q & {N_CH{enable}};
        capture_c = hit_edge & (~pending_q | grant);
        pending_d = (pending_q & ~grant) | capture_c;
        drop_d    = drop_q | (hit_edge & pending_q & ~grant);
        coarse_d  = enable ? coarse_q + COARSE_W'(1) : '0;
        wrap_d    = enable && (&coarse_q);
    end

    always_comb begin
        push_ts         = '0;
        push_ts.channel = gnt_idx;
        push_ts.coarse  = st_coarse_q[gnt_idx];
        push_ts.fine    = st_fine_q[gnt_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coarse_q  <= '0;
            wrap_q    <= 1'b0;
            hit_q     <= '0;
            pending_q <= '0;
            drop_q    <= '0;
            ptr_q     <= '0;
        end else begin
            coarse_q  <= coarse_d;
            wrap_q    <= wrap_d;
            hit_q     <= hit_in;
            pending_q <= pending_d;
            drop_q    <= drop_d;
            ptr_q     <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (capture_c[c]) begin
                st_coarse_q[c] <= coarse_q;
                st_fine_q[c]   <= fine_c[c];
            end
        end
    end

    tdc_ts_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (ts_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (found),
        .push_data_i (push_ts),
        .pop_i       (out_ready),
        .head_o      (head_ts),
        .valid_o     (fifo_valid),
        .full_o      (fifo_full)
    );

    assign out_valid   = fifo_valid;
    assign out_channel = head_ts.channel;
    assign out_coarse  = head_ts.coarse;
    assign out_fine    = head_ts.fine;
    assign drop_flags  = drop_q;
    assign coarse_wrap = wrap_q;

endmodule

// File: tb/tb_tdc_multi_channel.sv
// tb/tb_tdc_multi_channel.sv - scoreboard bench for tdc_multi_channel with a transaction-level reference model
module tb_tdc_multi_channel;

    localparam int N  = 4;
    localparam int TW = 8;
    localparam int CW = 5;
    localparam int D  = 8;

    typedef struct { int ch; int coarse; int fine; } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic [N-1:0]    hit_in = '0;
    logic [N*TW-1:0] thermo_in = '0;
    logic            out_ready = 1'b0;
    logic            out_valid;
    logic [1:0]      out_channel;
    logic [CW-1:0]   out_coarse;
    logic [3:0]      out_fine;
    logic [N-1:0]    drop_flags;
    logic            coarse_wrap;

    always #5 clk = ~clk;

    tdc_multi_channel #(.N_CH(N), .THERMO_W(TW), .COARSE_W(CW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .enable(enable), .hit_in(hit_in), .thermo_in(thermo_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
        .out_coarse(out_coarse), .out_fine(out_fine), .drop_flags(drop_flags),
        .coarse_wrap(coarse_wrap)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    exp_t exp_q[$];
    exp_t popped[$];

    int       mcoarse = 0, mptr = 0, mcnt = 0;
    bit       mwrap = 0, mafter_rst = 0;
    bit [N-1:0] mhit = '0, mpend = '0, mdrop = '0;
    int       mst_c[N], mst_f[N];
    bit       exp_valid = 0, exp_wrap = 0, exp_zero = 0;
    bit [N-1:0] exp_drop = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int fine_of(input logic [TW-1:0] w);
        int n = 0;
`ifdef TDC_BUBBLE_FIX_EN
        for (int i = 0; i < TW; i++) begin
            int lo, hi;
            lo = (i == 0) ? 1 : int'(w[i-1]);
            hi = (i == TW-1) ? 0 : int'(w[i+1]);
            if (lo + int'(w[i]) + hi >= 2) n++;
        end
`else
        n = $countones(w);
`endif
        return n;
    endfunction

    // Reference model: advances one clock using the inputs just driven.
    task automatic model_step();
        int g;
        exp_valid = (mcnt > 0);
        exp_wrap  = mwrap;
        exp_drop  = mdrop;
        exp_zero  = mafter_rst;
        if (rst) begin
            mcoarse = 0; mwrap = 0; mhit = '0; mpend = '0; mdrop = '0;
            mptr = 0; mcnt = 0; mafter_rst = 1;
            exp_q.delete();
            return;
        end
        mafter_rst = 0;
        g = -1;
        if (mcnt < D)
            for (int i = 0; i < N; i++)
                if (g < 0 && mpend[(mptr + i) % N]) g = (mptr + i) % N;
        if (g >= 0) begin
            exp_q.push_back('{g, mst_c[g], mst_f[g]});
            mpend[g] = 0;
            mptr = (g + 1) % N;
            mcnt++;
        end
        if (exp_valid && out_ready) mcnt--;
        for (int c = 0; c < N; c++) begin
            if (hit_in[c] && !mhit[c] && enable) begin
                if (mpend[c]) mdrop[c] = 1;
                else begin
                    mpend[c] = 1;
                    mst_c[c] = mcoarse;
                    mst_f[c] = fine_of(thermo_in[c*TW +: TW]);
                end
            end
        end
        mhit    = hit_in;
        mwrap   = enable && (mcoarse == (1 << CW) - 1);
        mcoarse = enable ? (mcoarse + 1) % (1 << CW) : 0;
    endtask

    task automatic step(input logic [N-1:0] h, input logic [N*TW-1:0] th,
                        input logic en, input logic rdy, input logic r);
        @(negedge clk);
        hit_in = h; thermo_in = th; enable = en; out_ready = rdy; rst = r;
        model_step();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step('0, '0, 1'b1, rdy, 1'b0);
    endtask

    task automatic wait_coarse(input int tgt);
        int k = 0;
        while (mcoarse != tgt && k < 64) begin idle(1, 1'b1); k++; end
        if (k == 64) check("wait_coarse_timeout", 64'(mcoarse), 64'(tgt));
    endtask

    initial begin : monitor
        exp_t a, e;
        forever begin
            @(negedge clk); #3;
            if (chk_en) begin
                check("out_valid", 64'(out_valid), 64'(exp_valid));
                check("coarse_wrap", 64'(coarse_wrap), 64'(exp_wrap));
                check("drop_flags", 64'(drop_flags), 64'(exp_drop));
                if (exp_zero) check("rst_data_zero", 64'({out_channel, out_coarse, out_fine}), 64'd0);
                if (out_valid && out_ready) begin
                    a = '{int'(out_channel), int'(out_coarse), int'(out_fine)};
                    popped.push_back(a);
                    check("scoreboard_nonempty", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("entry", {16'(a.ch), 32'(a.coarse), 16'(a.fine)},
                                       {16'(e.ch), 32'(e.coarse), 16'(e.fine)});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int n0, k, first_coarse, idx;
        logic [N-1:0] h;
        logic [N*TW-1:0] th;
        logic [TW-1:0] w;
        step('0, '0, 1'b0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b0, 1'b1);
        chk_en = 1;
        step('0, '0, 1'b0, 1'b1, 1'b0);

        // single hit on ch2 at coarse 5
        n0 = popped.size();
        wait_coarse(5);
        step(4'b0100, 32'h001F_0000, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b1);
        check("t1_count", 64'(popped.size() - n0), 64'd1);
        if (popped.size() > n0)
            check("t1_entry", {16'(popped[n0].ch), 16'(popped[n0].coarse), 16'(popped[n0].fine)},
                              {16'd2, 16'd5, 16'd5});

        // simultaneous hits from ptr=0
        step('0, '0, 1'b1, 1'b1, 1'b1);
        n0 = popped.size();
        wait_coarse(20);
        step(4'b1011, 32'h00F0_3C07, 1'b1, 1'b1, 1'b0);
        idle(6, 1'b1);
        check("t2_count", 64'(popped.size() - n0), 64'd3);
        if (popped.size() >= n0 + 3) begin
            check("t2_order", {8'(popped[n0].ch), 8'(popped[n0+1].ch), 8'(popped[n0+2].ch)},
                              {8'd0, 8'd1, 8'd3});
            check("t2_coarse", {8'(popped[n0].coarse), 8'(popped[n0+1].coarse), 8'(popped[n0+2].coarse)},
                               {8'd20, 8'd20, 8'd20});
        end

        // lost hit with the FIFO full
        k = 0;
        while (mcnt < D && k < 64) begin
            step(4'(1 << ((k % 3 == 0) ? 0 : (k % 3 == 1) ? 2 : 3)), 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
            step('0, '0, 1'b1, 1'b0, 1'b0);
            k++;
        end
        if (k == 64) check("t3_fill_timeout", 64'(mcnt), 64'(D));
        n0 = popped.size();
        first_coarse = mcoarse;
        step(4'b0010, 32'h0000_0300, 1'b1, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0, 1'b0);
        step(4'b0010, 32'h0000_FF00, 1'b1, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0, 1'b0);
        #3;
        check("t3_drop_flags", 64'(drop_flags), 64'b0010);
        idle(14, 1'b1);
        idx = -1;
        for (int i = n0; i < popped.size(); i++) if (popped[i].ch == 1) idx = i;
        check("t3_ch1_seen", 64'(idx >= 0), 64'd1);
        if (idx >= 0)
            check("t3_first_stamp", {32'(popped[idx].coarse), 32'(popped[idx].fine)},
                                    {32'(first_coarse), 32'd2});

        // wrap: hit in the cycle where the counter reads 0 after 31
        k = 0;
        do begin idle(1, 1'b1); k++; end while (mcoarse != 0 && k < 64);
        n0 = popped.size();
        step(4'b0001, 32'h0000_00FF, 1'b1, 1'b1, 1'b0);
        #3;
        check("t4_wrap_pulse", 64'(coarse_wrap), 64'd1);
        check("t4_counter_zero", 64'(dut.coarse_q), 64'd0);
        idle(4, 1'b1);
        check("t4_count", 64'(popped.size() - n0), 64'd1);
        if (popped.size() > n0)
            check("t4_entry", {16'(popped[n0].ch), 16'(popped[n0].coarse), 16'(popped[n0].fine)},
                              {16'd0, 16'd0, 16'd8});

        // bubble in the thermometer word
        n0 = popped.size();
        step(4'b1000, 32'h0D00_0000, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b1);
        check("t5_count", 64'(popped.size() - n0), 64'd1);
        if (popped.size() > n0)
`ifdef TDC_BUBBLE_FIX_EN
            check("t5_fine", 64'(popped[n0].fine), 64'd4);
`else
            check("t5_fine", 64'(popped[n0].fine), 64'd3);
`endif

        // reset with entries queued, then hits while disabled
        step(4'b0111, 32'h0001_0307, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b0);
        step('0, '0, 1'b1, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1, 1'b0);
        #3;
        check("t6_valid_after_rst", 64'(out_valid), 64'd0);
        check("t6_drop_after_rst", 64'(drop_flags), 64'd0);
        n0 = popped.size();
        for (int i = 0; i < 3; i++) begin
            step(4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
            step('0, '0, 1'b0, 1'b1, 1'b0);
        end
        #3;
        check("t6_disabled_valid", 64'(out_valid), 64'd0);
        check("t6_disabled_pops", 64'(popped.size() - n0), 64'd0);

        // randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic en, rdy, r;
            h = 4'($urandom) & 4'($urandom);
            for (int c = 0; c < N; c++) begin
                w = 8'((16'd1 << $urandom_range(8, 0)) - 16'd1);
                if ($urandom_range(3, 0) == 0) w[$urandom_range(7, 0)] ^= 1'b1;
                th[c*TW +: TW] = w;
            end
            en  = ($urandom_range(15, 0) != 0);
            rdy = ($urandom_range(3, 0) != 0);
            r   = ($urandom_range(499, 0) == 0);
            if (r) rdy = 1'b0;
            step(h, th, en, rdy, r);
        end
        idle(40, 1'b1);
        check("final_drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
